mem_ldst_unit: RTL
==================

// Module: mem_ldst_unit
// PURPOSE
//   Load/store front-end sitting directly upstream of port A of the dual-port block RAM (mem).
//   Accepts CPU load/store requests over a valid/ready handshake.
//   Drives the RAM's addr/data/we pins and absorbs its 1-cycle registered read latency.
//   Returns load data over a valid/ready response channel; flags out-of-range accesses.
// PARAMETERS
//   DATA_WIDTH  16  word width; must match mem
//   ADDR_WIDTH  10  RAM address width; must match mem
//   CPU_AW      16  CPU-side address width; bits [CPU_AW-1:ADDR_WIDTH] must be zero
// PORTS
//   clk        in   1           single clock, all state updates on posedge
//   reset      in   1           synchronous, active-high
//   req_valid  in   1           request present
//   req_ready  out  1           unit can accept; high only in IDLE
//   req_we     in   1           1 = store, 0 = load
//   req_addr   in   CPU_AW      word address
//   req_wdata  in   DATA_WIDTH  store data
//   req_be     in   2           byte enables [1]=hi [0]=lo; used only with LDST_BYTE_EN
//   rsp_valid  out  1           load response present
//   rsp_ready  in   1           consumer takes response
//   rsp_data   out  DATA_WIDTH  load data, registered, stable while rsp_valid
//   rsp_err    out  1           response is for an out-of-range load
//   fault      out  1           sticky: any out-of-range access seen since reset
//   mem_addr   out  ADDR_WIDTH  to mem addr_a
//   mem_data   out  DATA_WIDTH  to mem data_a
//   mem_we     out  1           to mem we_a
//   mem_q      in   DATA_WIDTH  from mem out_a; valid the cycle after addr is sampled
// BEHAVIOUR
//   Reset: state=IDLE; rsp_valid=0, rsp_data=0, rsp_err=0, fault=0, mem_we=0.
//   Reset mid-operation aborts; no pending write is issued after reset.
//   Accept = req_valid & req_ready. req_ready = (state==IDLE).
//   In IDLE, mem_addr/mem_data/mem_we are driven combinationally from req_*.
//     RAM therefore samples on the accept edge N.
//   Range: oor = |req_addr[CPU_AW-1:ADDR_WIDTH].
//     An oor access forces mem_we=0 and sets fault at edge N.
//   Store, in range: mem_we=1 at edge N; no response.
//     Stays IDLE, so back-to-back stores sustain 1 per cycle.
//   Load: IDLE->RD at edge N.
//     Edge N+1: rsp_data<=mem_q (0 if oor), rsp_err<=oor, rsp_valid<=1; RD->RSP.
//     Load-to-use latency = 1 cycle after accept.
//   RSP: hold rsp_* until rsp_valid&rsp_ready.
//     Handshake edge: rsp_valid<=0, rsp_err<=0; RSP->IDLE (next accept earliest the following edge).
//   Outside IDLE/RMW_WR: mem_we=0; mem_addr holds the latched address.
//   Unknown state encodings recover to IDLE.
// CONFIGURATION
//   LDST_BYTE_EN defined: stores with req_be!=2'b11 use read-modify-write.
//     Edge N: read; IDLE->RMW_RD.
//     Edge N+1: merge mem_q with req_wdata per saved be; ->RMW_WR.
//     RMW_WR drives mem_we=1 with the merged word; edge N+2 writes; ->IDLE.
//     req_ready is low throughout.
//     be==2'b00: no-op store, no RAM access. be==2'b11: plain 1-cycle store.
//     Loads ignore be.
//   LDST_BYTE_EN undefined: req_be ignored; every store writes the full word; RMW states absent.
// STRUCTURE
//   mem_pkg: DATA_WIDTH/ADDR_WIDTH defaults, state encoding
//     (IDLE, RD, RSP, RMW_RD, RMW_WR), byte-enable constants.
//   Sub-module ldst_byte_merge: combinational (old, new, be) -> merged word;
//     instantiated only under LDST_BYTE_EN.
// TESTING
//   Bench pairs the unit with mem; port B idle.
//   1 Reset held 2 cycles mid-load -> rsp_valid=0, fault=0, req_ready=1 on first post-reset cycle.
//   2 Store 0x000<=0xDEAD, store 0x001<=0xBEAF, back-to-back ->
//     req_ready stays 1; loads then return 0xDEAD, 0xBEAF, each rsp_valid 1 cycle after accept.
//   3 Load 0x001 with rsp_ready=0 for 3 cycles -> rsp_data=0xBEAF stable, req_ready=0;
//     after handshake, IDLE next cycle.
//   4 Load 0x0400 -> rsp_err=1, rsp_data=0, fault=1 and sticky;
//     store to 0xFC00 -> mem_we never asserted.
//   5 LDST_BYTE_EN: 0x002=0x1234, store be=2'b01 data 0xAB -> reads 0x12AB;
//     be=2'b10 data 0xCD00 -> 0xCDAB; req_ready low exactly 2 cycles each.
//   6 LDST_BYTE_EN: store be=2'b00 -> RAM contents unchanged, mem_we=0.

Source files
------------

// File: rtl/mem_pkg.sv
// ----------------------------------------------------------------------------
// mem_pkg
//   Shared definitions for the block-RAM load/store front-end:
//   default RAM geometry, the load/store FSM state encoding and the byte-enable
//   constants.
// ----------------------------------------------------------------------------
package mem_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_CPU_AW     = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RSP    = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4
    } ldst_state_e;

    localparam logic [1:0] BE_NONE = 2'b00;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_ALL  = 2'b11;

endpackage

// File: rtl/ldst_byte_merge.sv
// ----------------------------------------------------------------------------
// ldst_byte_merge
//   Combinational byte merge for partial stores: each half of the result comes
//   from new_word when its enable is set, otherwise from old_word.
// Ports:
//   old_word  in   DATA_WIDTH  word currently held in RAM
//   new_word  in   DATA_WIDTH  store data
//   be        in   2           [1] = high half, [0] = low half
//   merged    out  DATA_WIDTH  word to write back
// ----------------------------------------------------------------------------
module ldst_byte_merge #(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] old_word,
    input  logic [DATA_WIDTH-1:0] new_word,
    input  logic [1:0]            be,
    output logic [DATA_WIDTH-1:0] merged
);

    localparam int HALF = DATA_WIDTH / 2;

    always_comb begin
        // NOTE: full default first so no path leaves merged unassigned (no latch).
        merged = old_word;
        if (be[0]) merged[HALF-1:0]          = new_word[HALF-1:0];
        if (be[1]) merged[DATA_WIDTH-1:HALF] = new_word[DATA_WIDTH-1:HALF];
    end

endmodule

// File: rtl/mem_ldst_unit.sv
// ----------------------------------------------------------------------------
// mem_ldst_unit
//   Load/store front-end for port A of the dual-port block RAM. Accepts CPU
//   requests on a valid/ready handshake, drives the RAM pins, absorbs the RAM's
//   1-cycle registered read latency and returns load data on a valid/ready
//   response channel. Accesses with any address bit above the RAM range set are
//   out of range: they never write, loads return 0 with rsp_err, and the sticky
//   fault flag is raised.
// Configuration macro: LDST_BYTE_EN -- partial stores (req_be != 2'b11) become
//   read-modify-write; without it req_be is ignored and every store is full-word.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   req_we/req_addr/req_wdata    store flag, CPU word address, store data
//   req_be                       byte enables (only with LDST_BYTE_EN)
//   rsp_valid/rsp_ready          load response handshake
//   rsp_data/rsp_err             load data, out-of-range flag
//   fault                        sticky out-of-range indicator
//   mem_addr/mem_data/mem_we     to RAM port A
//   mem_q                        from RAM port A (valid cycle after address)
// ----------------------------------------------------------------------------
module mem_ldst_unit
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int CPU_AW     = DEF_CPU_AW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [CPU_AW-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  fault,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    ldst_state_e           state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  oor_q;
    logic                  oor;
    logic                  accept;
    logic                  store_full;

    assign oor       = |req_addr[CPU_AW-1:ADDR_WIDTH];
    assign req_ready = (state == IDLE);
    // Reset gates accept so a store presented during reset never reaches the RAM.
    assign accept    = req_valid & req_ready & ~reset;

`ifdef LDST_BYTE_EN
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] merged_d;
    logic [DATA_WIDTH-1:0] merged_q;
    logic [1:0]            be_q;
    logic                  store_rmw;

    assign store_full = req_we & (req_be == BE_ALL);
    assign store_rmw  = req_we & (req_be != BE_ALL) & (req_be != BE_NONE);

    // mem_q in RMW_RD is the old word at addr_q, read on the accept edge.
    ldst_byte_merge #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_merge (
        .old_word(mem_q),
        .new_word(wdata_q),
        .be      (be_q),
        .merged  (merged_d)
    );

    // NOTE: pure datapath registers are left unreset; they are only consumed in
    // states that are entered after they have been loaded.
    always_ff @(posedge clk) begin
        if (accept && state == IDLE && store_rmw && !oor) begin
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
        if (state == RMW_RD) merged_q <= merged_d;
    end
`else
    logic unused_be;
    assign unused_be  = ^req_be;
    assign store_full = req_we;
`endif

    // RAM pins: pass-through from the request in IDLE so the RAM samples on the
    // accept edge; otherwise hold the latched address with writes off.
    always_comb begin
        mem_addr = addr_q;
        mem_data = '0;
        mem_we   = 1'b0;
        case (state)
            IDLE: begin
                mem_addr = req_addr[ADDR_WIDTH-1:0];
                mem_data = req_wdata;
                mem_we   = accept & store_full & ~oor;
            end
`ifdef LDST_BYTE_EN
            RMW_WR: begin
                mem_data = merged_q;
                mem_we   = ~reset;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: non-blocking assignments throughout clocked logic.
            state     <= IDLE;
            addr_q    <= '0;
            oor_q     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            fault     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q <= req_addr[ADDR_WIDTH-1:0];
                        oor_q  <= oor;
                        if (oor) fault <= 1'b1;
                        if (!req_we) state <= RD;
`ifdef LDST_BYTE_EN
                        else if (store_rmw && !oor) state <= RMW_RD;
`endif
                    end
                end
                RD: begin
                    rsp_data  <= oor_q ? '0 : mem_q;
                    rsp_err   <= oor_q;
                    rsp_valid <= 1'b1;
                    state     <= RSP;
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        state     <= IDLE;
                    end
                end
`ifdef LDST_BYTE_EN
                RMW_RD: state <= RMW_WR;
                RMW_WR: state <= IDLE;
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
